// File: rtl/paddle_cmd_master_if.sv
// rtl/paddle_cmd_master_if.sv - paddle command link between button master and pong core
interface paddle_cmd_master_if;
  logic [31:0] dataa;   // command word: [9] player, [8:0] y
  logic        CLK_EN;  // command strobe, core latches dataa on its rising edge
  logic [31:0] result;  // score word from the core

  modport master (output dataa, output CLK_EN, input result);
  modport slave  (input dataa, input CLK_EN, output result);
endinterface

// File: rtl/paddle_cmd_master.sv
// rtl/paddle_cmd_master.sv - button-to-paddle command issuer for the pong core (option: PADDLE_ACCEL_EN)
module paddle_cmd_master #(
  parameter int STEP_DIV    = 500000,
  parameter int STEP_PX     = 2,
  parameter int Y_MAX       = 400,
  parameter int Y_INIT      = 200,
  parameter int GAP_CYC     = 4,
  parameter int ACCEL_TICKS = 8
) (
  input  logic                CLK,
  input  logic                i_rst,
  input  logic                btn_up1,
  input  logic                btn_dn1,
  input  logic                btn_up2,
  input  logic                btn_dn2,
  paddle_cmd_master_if.master link,
  output logic                game_over,
  output logic                busy
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             move;
  logic [GAP_W-1:0] gap_cnt;
  logic [8:0]       y1, y2, y1_nx, y2_nx;
  logic             pend1, pend2;
  logic             last_p;   // player of the most recently issued command
  logic             sel_p;    // player to be issued on the next SETUP entry
  logic             start;    // entering SETUP this cycle
  logic [9:0]       step1, step2;

  // Saturating move of one paddle; both or neither button leaves it in place
  function automatic logic [8:0] next_y(input logic [8:0] y, input logic up, input logic dn,
                                        input logic [9:0] step);
    logic [9:0] wide;
    wide = {1'b0, y};
    if (up && !dn) begin
      wide = (wide < step) ? 10'd0 : wide - step;
    end else if (dn && !up) begin
      wide = wide + step;
      if (wide > 10'(Y_MAX)) wide = 10'(Y_MAX);
    end
    return wide[8:0];
  endfunction

  assign tick  = (tick_cnt == CNT_W'(STEP_DIV - 1));
  assign move  = tick && !game_over;
  assign y1_nx = next_y(y1, btn_up1, btn_dn1, step1);
  assign y2_nx = next_y(y2, btn_up2, btn_dn2, step2);
  assign busy  = (state != IDLE);

`ifdef PADDLE_ACCEL_EN
  localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

  logic [HOLD_W-1:0] hold1, hold2;
  logic              dir1, dir2;  // direction of the current hold, 1 = down
  logic              unused_ok;

  assign step1     = (hold1 >= HOLD_W'(ACCEL_TICKS)) ? 10'(2 * STEP_PX) : 10'(STEP_PX);
  assign step2     = (hold2 >= HOLD_W'(ACCEL_TICKS)) ? 10'(2 * STEP_PX) : 10'(STEP_PX);
  assign unused_ok = ^link.result[31:4];

  // Count consecutive ticks with a single, unchanged direction held per player
  always_ff @(posedge CLK or posedge i_rst) begin
    if (i_rst) begin
      hold1 <= '0;
      hold2 <= '0;
      dir1  <= 1'b0;
      dir2  <= 1'b0;
    end else if (move) begin
      if (btn_up1 ^ btn_dn1) begin
        dir1 <= btn_dn1;
        if (hold1 != '0 && dir1 == btn_dn1) begin
          if (hold1 != HOLD_W'(ACCEL_TICKS)) hold1 <= hold1 + 1'b1;
        end else begin
          hold1 <= HOLD_W'(1);
        end
      end else begin
        hold1 <= '0;
      end
      if (btn_up2 ^ btn_dn2) begin
        dir2 <= btn_dn2;
        if (hold2 != '0 && dir2 == btn_dn2) begin
          if (hold2 != HOLD_W'(ACCEL_TICKS)) hold2 <= hold2 + 1'b1;
        end else begin
          hold2 <= HOLD_W'(1);
        end
      end else begin
        hold2 <= '0;
      end
    end
  end
`else
  logic unused_ok;

  assign step1     = 10'(STEP_PX);
  assign step2     = 10'(STEP_PX);
  assign unused_ok = ^{link.result[31:4], (ACCEL_TICKS > 0)};
`endif

  // Movement tick divider
  always_ff @(posedge CLK or posedge i_rst) begin
    if (i_rst) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // Game over is sticky until reset so play stays frozen at the final score
  always_ff @(posedge CLK or posedge i_rst) begin
    if (i_rst) game_over <= 1'b0;
    else if (link.result[1:0] == 2'b11 || link.result[3:2] == 2'b11) game_over <= 1'b1;
  end

  // Next state and issue selection; alternate players only when both wait behind a command
  always_comb begin
    state_nx = state;
    sel_p    = (pend1 && pend2) ? ((state == GAP) ? !last_p : 1'b0) : pend2;
    case (state)
      IDLE:    if (!game_over && (pend1 || pend2)) state_nx = SETUP;
      SETUP:   state_nx = PULSE;
      PULSE:   state_nx = GAP;
      GAP:     if (gap_cnt == GAP_W'(GAP_CYC - 1))
                 state_nx = (!game_over && (pend1 || pend2)) ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
    start = (state_nx == SETUP) && (state != SETUP);
  end

  // State register and link outputs; dataa is loaded on SETUP entry so it leads the strobe
  always_ff @(posedge CLK or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      last_p      <= 1'b1;
      link.dataa  <= '0;
      link.CLK_EN <= 1'b0;
    end else begin
      state       <= state_nx;
      link.CLK_EN <= (state_nx == PULSE);
      gap_cnt     <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (start) begin
        link.dataa <= {22'b0, sel_p, sel_p ? y2 : y1};
        last_p     <= sel_p;
      end
    end
  end

  // Paddle positions and pending flags; a tick setting pend overrides a same-cycle clear
  always_ff @(posedge CLK or posedge i_rst) begin
    if (i_rst) begin
      y1    <= 9'(Y_INIT);
      y2    <= 9'(Y_INIT);
      pend1 <= 1'b1;
      pend2 <= 1'b1;
    end else begin
      if (start && !sel_p) pend1 <= 1'b0;
      if (start && sel_p)  pend2 <= 1'b0;
      if (move) begin
        y1 <= y1_nx;
        y2 <= y2_nx;
        if (y1_nx != y1) pend1 <= 1'b1;
        if (y2_nx != y2) pend2 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_paddle_cmd_master.sv
// tb/tb_paddle_cmd_master.sv - directed self-checking bench for paddle_cmd_master
module tb_paddle_cmd_master;
  logic CLK     = 1'b0;
  logic i_rst   = 1'b1;
  logic btn_up1 = 1'b0;
  logic btn_dn1 = 1'b0;
  logic btn_up2 = 1'b0;
  logic btn_dn2 = 1'b0;
  logic game_over;
  logic busy;

  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cmd_q[$];
  int          rise_q[$];
  logic [31:0] exp_q[$];
  logic        en_q = 1'b0;

  paddle_cmd_master_if link();

  paddle_cmd_master #(
    .STEP_DIV(4), .STEP_PX(2), .Y_MAX(400), .Y_INIT(200), .GAP_CYC(4), .ACCEL_TICKS(8)
  ) dut (
    .CLK(CLK), .i_rst(i_rst),
    .btn_up1(btn_up1), .btn_dn1(btn_dn1), .btn_up2(btn_up2), .btn_dn2(btn_dn2),
    .link(link), .game_over(game_over), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Posedges since reset release; edge 1 is the first after release
  always @(posedge CLK or posedge i_rst) begin
    if (i_rst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Record every CLK_EN rise with the command word and the edge it rose on
  always @(negedge CLK) begin
    if (link.CLK_EN && !en_q) begin
      cmd_q.push_back(link.dataa);
      rise_q.push_back(cyc);
    end
    en_q <= link.CLK_EN;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cmd_at(input int i);
    return (i < cmd_q.size()) ? cmd_q[i] : 32'hffff_ffff;
  endfunction

  function automatic logic [31:0] rise_at(input int i);
    return (i < rise_q.size()) ? rise_q[i] : 32'hffff_ffff;
  endfunction

  function automatic logic [31:0] last_cmd();
    return (cmd_q.size() > 0) ? cmd_q[cmd_q.size() - 1] : 32'hffff_ffff;
  endfunction

  task automatic verify_cmds(input string tag);
    check({tag, ".count"}, cmd_q.size(), exp_q.size());
    foreach (exp_q[i]) check($sformatf("%s.cmd%0d", tag, i), cmd_at(i), exp_q[i]);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic do_reset();
    i_rst       = 1'b1;
    btn_up1     = 1'b0;
    btn_dn1     = 1'b0;
    btn_up2     = 1'b0;
    btn_dn2     = 1'b0;
    link.result = '0;
    repeat (2) @(negedge CLK);
    cmd_q.delete();
    rise_q.delete();
    i_rst = 1'b0;
  endtask

  initial begin
    int cnt;
    link.result = '0;

    // Reset values
    @(negedge CLK);
    check("rst.dataa", link.dataa, 32'h0);
    check("rst.clk_en", {31'b0, link.CLK_EN}, 32'h0);
    check("rst.busy", {31'b0, busy}, 32'h0);
    check("rst.game_over", {31'b0, game_over}, 32'h0);

    // Initial positions go out after release: bar1 at edge 2, bar2 six edges later
    do_reset();
    run_to(1);
    check("init.busy_e1", {31'b0, busy}, 32'h1);
    check("init.en_e1", {31'b0, link.CLK_EN}, 32'h0);
    check("init.dataa_e1", link.dataa, 32'h0C8);
    run_to(20);
    exp_q = '{32'h0C8, 32'h2C8};
    verify_cmds("init");
    check("init.rise0", rise_at(0), 32'd2);
    check("init.rise1", rise_at(1), 32'd8);
    check("init.idle", {31'b0, busy}, 32'h0);

    // Hold up1 across three ticks (edges 24, 28, 32)
    cmd_q.delete();
    rise_q.delete();
    btn_up1 = 1'b1;
    run_to(32);
    btn_up1 = 1'b0;
    run_to(60);
    exp_q = '{32'h0C6, 32'h0C4, 32'h0C2};
    verify_cmds("up1");
    check("up1.rise0", rise_at(0), 32'd26);
    check("up1.rise1", rise_at(1), 32'd32);
    check("up1.rise2", rise_at(2), 32'd38);

    // up1 and dn2 on the same tick: bar1 first, bar2 one slot later
    do_reset();
    run_to(20);
    cmd_q.delete();
    rise_q.delete();
    btn_up1 = 1'b1;
    btn_dn2 = 1'b1;
    run_to(24);
    btn_up1 = 1'b0;
    btn_dn2 = 1'b0;
    run_to(60);
    exp_q = '{32'h0C6, 32'h2CA};
    verify_cmds("both");
    check("both.rise0", rise_at(0), 32'd26);
    check("both.rise1", rise_at(1), 32'd32);

    // up1 held past the top: y=0 is sent once and never again
    do_reset();
    run_to(20);
    cmd_q.delete();
    rise_q.delete();
    btn_up1 = 1'b1;
    run_to(440);
    btn_up1 = 1'b0;
    run_to(480);
    cnt = 0;
    foreach (cmd_q[i]) if (cmd_q[i] == 32'h000) cnt++;
    check("top.zero_sends", cnt, 32'd1);
    check("top.last", last_cmd(), 32'h000);

    // dn2 held past the bottom: y=400 is sent once and never again
    do_reset();
    run_to(20);
    cmd_q.delete();
    rise_q.delete();
    btn_dn2 = 1'b1;
    run_to(440);
    btn_dn2 = 1'b0;
    run_to(480);
    cnt = 0;
    foreach (cmd_q[i]) if (cmd_q[i] == 32'h390) cnt++;
    check("bot.max_sends", cnt, 32'd1);
    check("bot.last", last_cmd(), 32'h390);

    // Game over raised during GAP: that GAP completes, then nothing more is issued
    do_reset();
    run_to(20);
    cmd_q.delete();
    rise_q.delete();
    btn_up1 = 1'b1;
    run_to(28);
    link.result = 32'h3;
    run_to(29);
    check("go.flag", {31'b0, game_over}, 32'h1);
    check("go.busy_in_gap", {31'b0, busy}, 32'h1);
    run_to(31);
    check("go.idle_after_gap", {31'b0, busy}, 32'h0);
    run_to(80);
    exp_q = '{32'h0C6};
    verify_cmds("go");
    btn_up1 = 1'b0;

    // Player 2 score triggers game over; non-final scores do not; flag is sticky
    do_reset();
    run_to(20);
    link.result = 32'h6;
    run_to(22);
    check("go2.not_over", {31'b0, game_over}, 32'h0);
    link.result = 32'hC;
    run_to(24);
    check("go2.over", {31'b0, game_over}, 32'h1);
    link.result = 32'h0;
    run_to(26);
    check("go2.sticky", {31'b0, game_over}, 32'h1);

    // Reset mid-pulse drops the strobe immediately
    do_reset();
    run_to(2);
    check("arst.pulse_high", {31'b0, link.CLK_EN}, 32'h1);
    #2 i_rst = 1'b1;
    #1;
    check("arst.clk_en", {31'b0, link.CLK_EN}, 32'h0);
    check("arst.dataa", link.dataa, 32'h0);
    check("arst.busy", {31'b0, busy}, 32'h0);

`ifdef PADDLE_ACCEL_EN
    // dn1 held ten ticks: eight steps of 2 then two of 4, ending at 224
    do_reset();
    run_to(20);
    cmd_q.delete();
    rise_q.delete();
    btn_dn1 = 1'b1;
    run_to(60);
    btn_dn1 = 1'b0;
    run_to(100);
    check("accel.last", last_cmd(), 32'h0E0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
